wbs_mem_bridge: RTL and testbench

Wishbone slave front-end of the user project. Decodes classic single-beat Wishbone cycles from the management core into control-register accesses and native-width SRAM accesses for the query, leaf, node and best-index memories. It pairs two 32-bit beats (lower then upper half) into one 64-bit memory write, and splits one 64-bit best-array read into two 32-bit beats. It sits between the user_proj_example Wishbone pins and the KD-tree/query memories and search FSM.

---
 rtl/wbs_pkg.sv | 34 +++
 rtl/wbs_addr_decode.sv | 52 +++++
 rtl/wbs_mem_bridge.sv | 261 ++++++++++++++++++++++++++
 tb/tb_wbs_mem_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wbs_pkg.sv
// Shared address map, region/register encodings and FSM states for the
// Wishbone-to-memory bridge.
package wbs_pkg;

    localparam int unsigned WB_DW    = 32;
    localparam int unsigned QUERY_DW = 55;
    localparam int unsigned LEAF_DW  = 64;
    localparam int unsigned NODE_DW  = 22;
    localparam int unsigned BEST_DW  = 64;

    localparam logic [31:0] ADDR_MASK      = 32'hFFFF_0000;
    localparam logic [31:0] MODE_ADDR      = 32'h3000_0000;
    localparam logic [31:0] DEBUG_ADDR     = 32'h3000_0004;
    localparam logic [31:0] DONE_ADDR      = 32'h3000_0008;
    localparam logic [31:0] FSM_START_ADDR = 32'h3000_000C;
    localparam logic [31:0] BUSY_ADDR      = 32'h3000_0010;
    localparam logic [31:0] QUERY_BASE     = 32'h3001_0000;
    localparam logic [31:0] LEAF_BASE      = 32'h3002_0000;
    localparam logic [31:0] BEST_BASE      = 32'h3003_0000;
    localparam logic [31:0] NODE_BASE      = 32'h3004_0000;

    typedef enum logic [2:0] {
        RGN_NONE, RGN_CTRL, RGN_QUERY, RGN_LEAF, RGN_BEST, RGN_NODE
    } region_e;

    typedef enum logic [2:0] {
        CR_NONE, CR_MODE, CR_DEBUG, CR_DONE, CR_START, CR_BUSY
    } ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_ACK, ST_RD_WAIT
    } state_e;

endpackage

// File: rtl/wbs_addr_decode.sv
// Combinational Wishbone address decode: region, control register, half
// select and per-memory word indices (upper index bits simply dropped).
module wbs_addr_decode
    import wbs_pkg::*;
#(
    parameter int unsigned QUERY_AW = 12,
    parameter int unsigned LEAF_AW  = 12,
    parameter int unsigned NODE_AW  = 6,
    parameter int unsigned BEST_AW  = 9
) (
    input  logic [31:0]         adr_i,
    output region_e             region_c,
    output ctrl_e               ctrl_c,
    output logic                upper_c,
    output logic [QUERY_AW-1:0] query_idx_c,
    output logic [LEAF_AW-1:0]  leaf_idx_c,
    output logic [BEST_AW-1:0]  best_idx_c,
    output logic [NODE_AW-1:0]  node_idx_c
);

    always_comb begin
        region_c = RGN_NONE;
        case (adr_i & ADDR_MASK)
            (MODE_ADDR & ADDR_MASK): region_c = RGN_CTRL;
            QUERY_BASE:              region_c = RGN_QUERY;
            LEAF_BASE:               region_c = RGN_LEAF;
            BEST_BASE:               region_c = RGN_BEST;
            NODE_BASE:               region_c = RGN_NODE;
            default:                 region_c = RGN_NONE;
        endcase
    end

    // Full-address match, so control offsets outside the map fall to CR_NONE.
    always_comb begin
        ctrl_c = CR_NONE;
        case (adr_i)
            MODE_ADDR:      ctrl_c = CR_MODE;
            DEBUG_ADDR:     ctrl_c = CR_DEBUG;
            DONE_ADDR:      ctrl_c = CR_DONE;
            FSM_START_ADDR: ctrl_c = CR_START;
            BUSY_ADDR:      ctrl_c = CR_BUSY;
            default:        ctrl_c = CR_NONE;
        endcase
    end

    assign upper_c     = adr_i[2];
    assign query_idx_c = adr_i[3 +: QUERY_AW];
    assign leaf_idx_c  = adr_i[3 +: LEAF_AW];
    assign best_idx_c  = adr_i[3 +: BEST_AW];
    assign node_idx_c  = adr_i[2 +: NODE_AW];

endmodule

// File: rtl/wbs_mem_bridge.sv
// Wishbone slave front-end: control registers, 2x32-bit -> 64-bit memory
// write pairing and cached 64-bit -> 2x32-bit best-index reads.
module wbs_mem_bridge
    import wbs_pkg::*;
#(
    parameter int unsigned QUERY_AW = 12,
    parameter int unsigned LEAF_AW  = 12,
    parameter int unsigned NODE_AW  = 6,
    parameter int unsigned BEST_AW  = 9
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [WB_DW-1:0]    wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [WB_DW-1:0]    wbs_dat_o,
    output logic                mode_o,
    output logic                debug_o,
    output logic                fsm_start_o,
    input  logic                fsm_busy_i,
    input  logic                fsm_done_i,
    output logic                query_we_o,
    output logic [QUERY_AW-1:0] query_addr_o,
    output logic [QUERY_DW-1:0] query_wdata_o,
    output logic                leaf_we_o,
    output logic [LEAF_AW-1:0]  leaf_addr_o,
    output logic [LEAF_DW-1:0]  leaf_wdata_o,
    output logic                node_we_o,
    output logic [NODE_AW-1:0]  node_addr_o,
    output logic [NODE_DW-1:0]  node_wdata_o,
    output logic                best_re_o,
    output logic [BEST_AW-1:0]  best_addr_o,
    input  logic [BEST_DW-1:0]  best_rdata_i
);

    region_e             region_c;
    ctrl_e               ctrl_c;
    logic                upper_c;
    logic [QUERY_AW-1:0] query_idx_c;
    logic [LEAF_AW-1:0]  leaf_idx_c;
    logic [BEST_AW-1:0]  best_idx_c;
    logic [NODE_AW-1:0]  node_idx_c;

    wbs_addr_decode #(
        .QUERY_AW (QUERY_AW),
        .LEAF_AW  (LEAF_AW),
        .NODE_AW  (NODE_AW),
        .BEST_AW  (BEST_AW)
    ) u_decode (
        .adr_i       (wbs_adr_i),
        .region_c    (region_c),
        .ctrl_c      (ctrl_c),
        .upper_c     (upper_c),
        .query_idx_c (query_idx_c),
        .leaf_idx_c  (leaf_idx_c),
        .best_idx_c  (best_idx_c),
        .node_idx_c  (node_idx_c)
    );

    state_e              state_q, state_d;
    logic                ack_q, ack_d, mode_q, mode_d, debug_q, debug_d, start_q, start_d;
    logic [WB_DW-1:0]    dat_q, dat_d, stage_q, stage_d;
    logic                query_we_q, query_we_d, leaf_we_q, leaf_we_d, node_we_q, node_we_d;
    logic [QUERY_AW-1:0] query_addr_q, query_addr_d;
    logic [QUERY_DW-1:0] query_wdata_q, query_wdata_d;
    logic [LEAF_AW-1:0]  leaf_addr_q, leaf_addr_d;
    logic [LEAF_DW-1:0]  leaf_wdata_q, leaf_wdata_d;
    logic [NODE_AW-1:0]  node_addr_q, node_addr_d;
    logic [NODE_DW-1:0]  node_wdata_q, node_wdata_d;
    logic [BEST_DW-1:0]  rbuf_q, rbuf_d;
    logic [BEST_AW-1:0]  rbuf_idx_q, rbuf_idx_d, rd_idx_q, rd_idx_d;
    logic                rbuf_vld_q, rbuf_vld_d, rd_upper_q, rd_upper_d;
    logic                best_re_c;
    logic [63:0]         wide_c;

    assign wide_c = {wbs_dat_i, stage_q};

    always_comb begin
        state_d       = state_q;
        ack_d         = 1'b0;
        dat_d         = '0;
        mode_d        = mode_q;
        debug_d       = debug_q;
        start_d       = 1'b0;
        stage_d       = stage_q;
        query_we_d    = 1'b0;
        query_addr_d  = query_addr_q;
        query_wdata_d = query_wdata_q;
        leaf_we_d     = 1'b0;
        leaf_addr_d   = leaf_addr_q;
        leaf_wdata_d  = leaf_wdata_q;
        node_we_d     = 1'b0;
        node_addr_d   = node_addr_q;
        node_wdata_d  = node_wdata_q;
        rbuf_d        = rbuf_q;
        rbuf_idx_d    = rbuf_idx_q;
        rbuf_vld_d    = rbuf_vld_q & ~fsm_busy_i;
        rd_idx_d      = rd_idx_q;
        rd_upper_d    = rd_upper_q;
        best_re_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (wbs_we_i) begin
                        if (|wbs_sel_i) begin
                            case (region_c)
                                RGN_CTRL: begin
                                    case (ctrl_c)
                                        CR_MODE:  mode_d  = wbs_dat_i[0];
                                        CR_DEBUG: debug_d = wbs_dat_i[0];
                                        CR_START: start_d = 1'b1;
                                        default:  ;
                                    endcase
                                end
                                RGN_QUERY: begin
                                    if (!fsm_busy_i && !upper_c) begin
                                        stage_d = wbs_dat_i;
                                    end else if (!fsm_busy_i) begin
                                        query_we_d    = 1'b1;
                                        query_addr_d  = query_idx_c;
                                        query_wdata_d = wide_c[QUERY_DW-1:0];
                                        stage_d       = '0;
                                    end
                                end
                                RGN_LEAF: begin
                                    if (!fsm_busy_i && !upper_c) begin
                                        stage_d = wbs_dat_i;
                                    end else if (!fsm_busy_i) begin
                                        leaf_we_d    = 1'b1;
                                        leaf_addr_d  = leaf_idx_c;
                                        leaf_wdata_d = wide_c;
                                        stage_d      = '0;
                                    end
                                end
                                RGN_NODE: begin
                                    if (!fsm_busy_i) begin
                                        node_we_d    = 1'b1;
                                        node_addr_d  = node_idx_c;
                                        node_wdata_d = wbs_dat_i[NODE_DW-1:0];
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        case (region_c)
                            RGN_CTRL: begin
                                case (ctrl_c)
                                    CR_MODE:  dat_d = WB_DW'(mode_q);
                                    CR_DEBUG: dat_d = WB_DW'(debug_q);
                                    CR_DONE:  dat_d = WB_DW'(fsm_done_i);
                                    CR_BUSY:  dat_d = WB_DW'(fsm_busy_i);
                                    default:  dat_d = '0;
                                endcase
                            end
                            RGN_BEST: begin
                                // Upper half of the word just fetched is served from rbuf.
                                if (upper_c && rbuf_vld_q && !fsm_busy_i && rbuf_idx_q == best_idx_c) begin
                                    dat_d = rbuf_q[63:32];
                                end else begin
                                    best_re_c  = 1'b1;
                                    rd_idx_d   = best_idx_c;
                                    rd_upper_d = upper_c;
                                    ack_d      = 1'b0;
                                    state_d    = ST_RD_WAIT;
                                end
                            end
                            default: dat_d = '0;
                        endcase
                    end
                end
            end
            ST_RD_WAIT: begin
                rbuf_d     = best_rdata_i;
                rbuf_idx_d = rd_idx_q;
                rbuf_vld_d = ~fsm_busy_i;
                dat_d      = rd_upper_q ? best_rdata_i[63:32] : best_rdata_i[31:0];
                ack_d      = 1'b1;
                state_d    = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            ack_q         <= 1'b0;
            dat_q         <= '0;
            mode_q        <= 1'b0;
            debug_q       <= 1'b0;
            start_q       <= 1'b0;
            stage_q       <= '0;
            query_we_q    <= 1'b0;
            query_addr_q  <= '0;
            query_wdata_q <= '0;
            leaf_we_q     <= 1'b0;
            leaf_addr_q   <= '0;
            leaf_wdata_q  <= '0;
            node_we_q     <= 1'b0;
            node_addr_q   <= '0;
            node_wdata_q  <= '0;
            rbuf_q        <= '0;
            rbuf_idx_q    <= '0;
            rbuf_vld_q    <= 1'b0;
            rd_idx_q      <= '0;
            rd_upper_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            dat_q         <= dat_d;
            mode_q        <= mode_d;
            debug_q       <= debug_d;
            start_q       <= start_d;
            stage_q       <= stage_d;
            query_we_q    <= query_we_d;
            query_addr_q  <= query_addr_d;
            query_wdata_q <= query_wdata_d;
            leaf_we_q     <= leaf_we_d;
            leaf_addr_q   <= leaf_addr_d;
            leaf_wdata_q  <= leaf_wdata_d;
            node_we_q     <= node_we_d;
            node_addr_q   <= node_addr_d;
            node_wdata_q  <= node_wdata_d;
            rbuf_q        <= rbuf_d;
            rbuf_idx_q    <= rbuf_idx_d;
            rbuf_vld_q    <= rbuf_vld_d;
            rd_idx_q      <= rd_idx_d;
            rd_upper_q    <= rd_upper_d;
        end
    end

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign mode_o        = mode_q;
    assign debug_o       = debug_q;
    assign fsm_start_o   = start_q;
    assign query_we_o    = query_we_q;
    assign query_addr_o  = query_addr_q;
    assign query_wdata_o = query_wdata_q;
    assign leaf_we_o     = leaf_we_q;
    assign leaf_addr_o   = leaf_addr_q;
    assign leaf_wdata_o  = leaf_wdata_q;
    assign node_we_o     = node_we_q;
    assign node_addr_o   = node_addr_q;
    assign node_wdata_o  = node_wdata_q;

    // The SRAM read strobe is issued in the request cycle so data returns in
    // RD_WAIT and the read acks two cycles after the request.
    assign best_re_o   = best_re_c & ~wb_rst_i;
    assign best_addr_o = best_re_o ? best_idx_c : '0;

endmodule

// File: tb/tb_wbs_mem_bridge.sv
// Self-checking bench for wbs_mem_bridge: bus transactions with a read/ack
// scoreboard, a memory-write scoreboard and a registered best-index SRAM model.
module tb_wbs_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        mode_o, debug_o, fsm_start_o;
    logic        fsm_busy_i, fsm_done_i;
    logic        query_we_o;
    logic [11:0] query_addr_o;
    logic [54:0] query_wdata_o;
    logic        leaf_we_o;
    logic [11:0] leaf_addr_o;
    logic [63:0] leaf_wdata_o;
    logic        node_we_o;
    logic [5:0]  node_addr_o;
    logic [21:0] node_wdata_o;
    logic        best_re_o;
    logic [8:0]  best_addr_o;
    logic [63:0] best_rdata_i;

    always #5 clk = ~clk;

    wbs_mem_bridge dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .mode_o        (mode_o),
        .debug_o       (debug_o),
        .fsm_start_o   (fsm_start_o),
        .fsm_busy_i    (fsm_busy_i),
        .fsm_done_i    (fsm_done_i),
        .query_we_o    (query_we_o),
        .query_addr_o  (query_addr_o),
        .query_wdata_o (query_wdata_o),
        .leaf_we_o     (leaf_we_o),
        .leaf_addr_o   (leaf_addr_o),
        .leaf_wdata_o  (leaf_wdata_o),
        .node_we_o     (node_we_o),
        .node_addr_o   (node_addr_o),
        .node_wdata_o  (node_wdata_o),
        .best_re_o     (best_re_o),
        .best_addr_o   (best_addr_o),
        .best_rdata_i  (best_rdata_i)
    );

    typedef struct { logic [31:0] dat; int lat; bit chk_dat; } bus_exp_t;
    typedef struct { int kind; logic [15:0] addr; logic [63:0] data; } wr_exp_t;

    bus_exp_t    bus_q[$];
    wr_exp_t     wr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          best_re_cnt = 0;
    int          start_cnt = 0;
    logic [63:0] best_mem [0:511];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Registered best-index SRAM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (best_re_o) begin
            best_rdata_i <= best_mem[best_addr_o];
            best_re_cnt  <= best_re_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (fsm_start_o) start_cnt++;
    end

    // Every memory write strobe must match the next expected write.
    always @(negedge clk) begin
        if (query_we_o || leaf_we_o || node_we_o) begin
            wr_exp_t e;
            wr_exp_t o;
            chk("one_strobe", 64'(query_we_o) + 64'(leaf_we_o) + 64'(node_we_o), 64'd1);
            o.kind = query_we_o ? 0 : (leaf_we_o ? 1 : 2);
            o.addr = query_we_o ? 16'(query_addr_o) : (leaf_we_o ? 16'(leaf_addr_o) : 16'(node_addr_o));
            o.data = query_we_o ? 64'(query_wdata_o) : (leaf_we_o ? leaf_wdata_o : 64'(node_wdata_o));
            chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                chk("wr_kind", 64'(o.kind), 64'(e.kind));
                chk("wr_addr", 64'(o.addr), 64'(e.addr));
                chk("wr_data", o.data, e.data);
            end
        end
    end

    task automatic exp_wr(input int kind, input logic [15:0] a, input logic [63:0] d);
        wr_exp_t e;
        e.kind = kind; e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic xfer(input string tag, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d, input int exp_lat);
        bus_exp_t e;
        int lat;
        bit got;
        logic [31:0] obs;
        e.dat = exp_d; e.lat = exp_lat; e.chk_dat = !w;
        bus_q.push_back(e);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ack) got = 1'b1;
        end
        obs = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        e = bus_q.pop_front();
        chk({tag, "_ack"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
            if (e.chk_dat) chk({tag, "_dat"}, 64'(obs), 64'(e.dat));
            @(posedge clk); #1;
            chk({tag, "_ack_drop"}, 64'(ack), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int s0;
        for (int i = 0; i < 512; i++) best_mem[i] = 64'h0;
        best_mem[5] = 64'hAAAA_5555_0000_01F3;
        best_mem[6] = 64'h1357_9BDF_2468_ACE0;
        best_rdata_i = '0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; wdat = '0; fsm_busy_i = 1'b0; fsm_done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_dat", 64'(rdat), 64'd0);
        chk("rst_mode", 64'(mode_o), 64'd0);
        chk("rst_debug", 64'(debug_o), 64'd0);
        chk("rst_start", 64'(fsm_start_o), 64'd0);
        chk("rst_strobes", 64'({query_we_o, leaf_we_o, node_we_o, best_re_o}), 64'd0);
        @(negedge clk); rst = 1'b0;

        xfer("mode_wr", 1, 32'h3000_0000, 32'h1, 32'h0, 1);
        chk("mode_o", 64'(mode_o), 64'd1);
        xfer("debug_wr", 1, 32'h3000_0004, 32'h1, 32'h0, 1);
        chk("debug_o", 64'(debug_o), 64'd1);
        xfer("mode_rd", 0, 32'h3000_0000, 32'h0, 32'h1, 1);

        exp_wr(2, 16'd2, 64'h1B801);
        xfer("node_wr", 1, 32'h3004_0008, (32'd55 << 11) | 32'd1, 32'h0, 1);

        xfer("leaf_lo", 1, 32'h3002_0010, 32'hDEAD_BEEF, 32'h0, 1);
        exp_wr(1, 16'd2, 64'h0123_4567_DEAD_BEEF);
        xfer("leaf_hi", 1, 32'h3002_0014, 32'h0123_4567, 32'h0, 1);

        xfer("query_lo", 1, 32'h3001_0008, 32'hCAFE_F00D, 32'h0, 1);
        exp_wr(0, 16'd1, 64'h007F_FFFF_CAFE_F00D);
        xfer("query_hi", 1, 32'h3001_000C, 32'hFFFF_FFFF, 32'h0, 1);
        exp_wr(0, 16'd2, 64'h0000_0012_0000_0000);
        xfer("query_hi_only", 1, 32'h3001_0014, 32'h12, 32'h0, 1);
        exp_wr(1, 16'd1, 64'h0000_00AB_0000_0000);
        xfer("leaf_trunc", 1, 32'h3002_800C, 32'hAB, 32'h0, 1);
        xfer("leaf_rd", 0, 32'h3002_0010, 32'h0, 32'h0, 1);

        c0 = best_re_cnt;
        xfer("best_lo5", 0, 32'h3003_0028, 32'h0, 32'h0000_01F3, 2);
        chk("best_lo5_re", 64'(best_re_cnt - c0), 64'd1);
        c0 = best_re_cnt;
        xfer("best_hi5", 0, 32'h3003_002C, 32'h0, 32'hAAAA_5555, 1);
        chk("best_hi5_re", 64'(best_re_cnt - c0), 64'd0);
        c0 = best_re_cnt;
        xfer("best_hi6", 0, 32'h3003_0034, 32'h0, 32'h1357_9BDF, 2);
        chk("best_hi6_re", 64'(best_re_cnt - c0), 64'd1);
        xfer("best_wr", 1, 32'h3003_0000, 32'h5, 32'h0, 1);

        s0 = start_cnt;
        xfer("start_wr", 1, 32'h3000_000C, 32'h1, 32'h0, 1);
        chk("start_pulses", 64'(start_cnt - s0), 64'd1);
        xfer("start_rd", 0, 32'h3000_000C, 32'h0, 32'h0, 1);

        fsm_busy_i = 1'b1; fsm_done_i = 1'b1;
        xfer("busy_leaf_hi", 1, 32'h3002_0004, 32'h2, 32'h0, 1);
        xfer("busy_rd", 0, 32'h3000_0010, 32'h0, 32'h1, 1);
        xfer("done_rd", 0, 32'h3000_0008, 32'h0, 32'h1, 1);
        c0 = best_re_cnt;
        xfer("busy_best_hi6", 0, 32'h3003_0034, 32'h0, 32'h1357_9BDF, 2);
        chk("busy_best_re", 64'(best_re_cnt - c0), 64'd1);
        fsm_busy_i = 1'b0; fsm_done_i = 1'b0;
        xfer("done_rd0", 0, 32'h3000_0008, 32'h0, 32'h0, 1);

        xfer("unmapped_rd", 0, 32'h3005_0000, 32'h0, 32'h0, 1);
        xfer("unmapped_wr", 1, 32'h3005_0004, 32'h1, 32'h0, 1);

        // Reset while a best read sits in RD_WAIT.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3003_0028;
        @(posedge clk); #1;
        chk("rdwait_noack", 64'(ack), 64'd0);
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ack", 64'(ack), 64'd0);
        chk("rst_mid_mode", 64'(mode_o), 64'd0);
        @(negedge clk); rst = 1'b0;
        c0 = best_re_cnt;
        xfer("post_rst_hi5", 0, 32'h3003_002C, 32'h0, 32'hAAAA_5555, 2);
        chk("post_rst_re", 64'(best_re_cnt - c0), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("wr_left", 64'(wr_q.size()), 64'd0);
        chk("bus_left", 64'(bus_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
